mem_responder: RTL

Memory responder serving the CPU's instruction-fetch and load/store requests over a single valid/ready request channel and a valid/ready response channel. It is the slave end of the CPU memory interface and replaces the DPI-backed memory model in synthesizable and FPGA builds. It decodes a word-addressed window at a configurable base, supports byte-masked writes and programmable wait states, and flags out-of-window or misaligned accesses.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_lfsr.sv | 26 ++
 rtl/mem_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types, constants and helpers for the memory responder.
//   mem_state_t   - responder FSM state encoding (IDLE, WAIT, RESP)
//   MEM_LFSR_SEED - reset value of the stall-generator LFSR
//   mem_addr_err  - flags misaligned or out-of-window word accesses
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam logic [15:0] MEM_LFSR_SEED = 16'hACE1;

   // The upper bound is computed in 33 bits so a window ending at 4 GiB does not wrap.
   function automatic logic mem_addr_err(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int unsigned depth);
      logic [32:0] lim;
      lim = {1'b0, base} + ({1'b0, depth} << 2);
      return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= lim);
   endfunction

endpackage

// File: rtl/mem_lfsr.sv
// mem_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) used to generate random stalls.
// Ports:
//   clk - clock, rising edge
//   rst - asynchronous active-high reset, loads MEM_LFSR_SEED
//   q   - current LFSR state, advances every cycle
module mem_lfsr
   import mem_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);

   logic fb;

   assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= MEM_LFSR_SEED;
      end else begin
         q <= {q[14:0], fb};
      end
   end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: slave end of the CPU memory interface. Accepts one request at a time on a
// valid/ready channel, waits a programmable number of cycles, performs the access once on
// entry to the response state and holds the response until the requester takes it.
// Optional feature macro: MEM_RANDOM_STALL_EN adds LFSR-driven extra latency (0..3 cycles)
// and random req_ready drops while idle.
// Ports:
//   clk, rst                 - clock and asynchronous active-high reset
//   req_valid / req_ready    - request handshake
//   req_addr, req_wen        - byte address, 1 = write
//   req_wdata, req_wmask     - write data and byte enables
//   rsp_valid / rsp_ready    - response handshake
//   rsp_rdata, rsp_err       - read data (0 for writes/errors), access error flag
module mem_responder
   import mem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wmask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   mem_state_t  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q;
   logic        wen_q;
   logic [3:0]  wmask_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic        accept;
   logic        stall;
   logic [4:0]  lat_eff;

`ifdef MEM_RANDOM_STALL_EN
   logic [15:0] lfsr;
   logic        unused_lfsr;

   mem_lfsr u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (lfsr)
   );

   assign lat_eff     = 5'(LATENCY) + {3'b000, lfsr[1:0]};
   assign stall       = lfsr[2];
   assign unused_lfsr = ^lfsr[15:3];
`else
   assign lat_eff = 5'(LATENCY);
   assign stall   = 1'b0;
`endif

   assign req_ready = (state_q == IDLE) && !rst && !stall;
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (lat_eff == 5'd0) begin
                  state_d = RESP;
                  cnt_d   = 5'd0;
               end else begin
                  state_d = WAIT;
                  cnt_d   = lat_eff;
               end
            end
         end
         WAIT: begin
            if (cnt_q < 5'd2) begin
               state_d = RESP;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // With zero latency the access executes on the accepting edge, before the request is
   // latched, so the live request fields are used while in IDLE.
   logic        exec;
   logic [31:0] acc_addr, acc_wdata, acc_off;
   logic        acc_wen, acc_err;
   logic [3:0]  acc_wmask;
   logic [AW-1:0] acc_idx;

   assign exec      = (state_d == RESP) && (state_q != RESP) && !rst;
   assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
   assign acc_wen   = (state_q == IDLE) ? req_wen   : wen_q;
   assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
   assign acc_wmask = (state_q == IDLE) ? req_wmask : wmask_q;
   assign acc_err   = mem_addr_err(acc_addr, BASE_ADDR, DEPTH_WORDS);
   assign acc_off   = acc_addr - BASE_ADDR;
   assign acc_idx   = AW'(acc_off >> 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= req_addr;
            wen_q   <= req_wen;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
         end
         if (exec) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || acc_wen) ? '0 : mem[acc_idx];
         end
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (exec && acc_wen && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_wmask[b]) begin
               mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
         end
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule
